right_shifter_seq: RTL and testbench

RIGHT_SHIFTER_SEQ -- requirements
Module: right_shifter_seq

---
 rtl/right_shifter_seq.sv | 138 +++++++++++++
 tb/tb_right_shifter_seq.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/right_shifter_seq.sv
// right_shifter_seq
// -----------------
// Bit-serial right shifter for the RV64 shift instructions SRL, SRA, SRLW and
// SRAW. An accepted request moves the operand right by one bit per clock, so
// a shift by N takes N+1 cycles from acceptance to the done pulse.
//
// Ports
//   clk    : single clock, all state changes on the rising edge
//   reset  : synchronous, active-high reset
//   start  : request strobe, only looked at while idle
//   A      : value to be shifted right
//   B      : shift amount source, B[5:0] (64-bit) or B[4:0] (word mode)
//   arith  : 0 = logical shift, 1 = arithmetic shift
//   word   : 1 = W-variant, works on A[31:0] and sign-extends the result
//   S      : registered result, held until the next request completes
//   busy   : high whenever the unit is not idle
//   done   : one-cycle pulse marking S as valid

module right_shifter_seq #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] B,
    input  logic            arith,
    input  logic            word,
    output logic [XLEN-1:0] S,
    output logic            busy,
    output logic            done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t          state;
    logic [XLEN-1:0] operand;
    logic [5:0]      count;
    logic            arith_q;
    logic            word_q;

    logic [XLEN-1:0] preload;
    logic [5:0]      preload_count;
    logic [XLEN-1:0] shifted;

    // Only the low shift-amount bits matter; the rest of B is deliberately
    // dropped here so the intent is visible.
    logic unused_b;
    assign unused_b = &{1'b0, B[XLEN-1:6]};

    // Word mode starts from the low half of A, extended according to the
    // shift type so that the vacated bits fill correctly as it shifts.
    always_comb begin
        preload = A;
        if (word) begin
            if (arith) begin
                preload = {{32{A[31]}}, A[31:0]};
            end else begin
                preload = {32'b0, A[31:0]};
            end
        end
        preload_count = word ? {1'b0, B[4:0]} : B[5:0];
    end

    // One step of the serial shift, using the latched shift type so that
    // input changes after acceptance cannot disturb the operation.
    assign shifted = {arith_q & operand[XLEN-1], operand[XLEN-1:1]};

    // Final result formatting: W-variants always sign-extend bit 31 of the
    // 32-bit result, even for logical shifts (a zero-length SRLW of a value
    // with bit 31 set yields a negative 64-bit result).
    function automatic logic [XLEN-1:0] finish_result(input logic [XLEN-1:0] value,
                                                      input logic            is_word);
        if (is_word) begin
            return {{32{value[31]}}, value[31:0]};
        end
        return value;
    endfunction

    // Single sequencer: IDLE accepts a request, SHIFT moves one bit per
    // cycle, DONE presents the one-cycle done pulse. S is only written on
    // the edge entering DONE, so it holds steady throughout SHIFT. busy and
    // done are registered alongside the state so they follow it exactly.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            operand <= '0;
            count   <= '0;
            arith_q <= 1'b0;
            word_q  <= 1'b0;
            S       <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        operand <= preload;
                        count   <= preload_count;
                        arith_q <= arith;
                        word_q  <= word;
                        busy    <= 1'b1;
                        if (preload_count == 6'd0) begin
                            state <= DONE;
                            S     <= finish_result(preload, word);
                            done  <= 1'b1;
                        end else begin
                            state <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    operand <= shifted;
                    count   <= count - 6'd1;
                    if (count == 6'd1) begin
                        state <= DONE;
                        S     <= finish_result(shifted, word_q);
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_right_shifter_seq.sv
// tb_right_shifter_seq
// --------------------
// Self-checking bench for right_shifter_seq. Each request pushes its expected
// result and latency into a scoreboard; the entries are popped and compared
// when the done pulse appears.

module tb_right_shifter_seq;

    logic        clk;
    logic        reset;
    logic        start;
    logic [63:0] A;
    logic [63:0] B;
    logic        arith;
    logic        word;
    logic [63:0] S;
    logic        busy;
    logic        done;

    int total;
    int passed;

    logic [63:0] exp_q[$];
    int          lat_q[$];

    right_shifter_seq #(.XLEN(64)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .A     (A),
        .B     (B),
        .arith (arith),
        .word  (word),
        .S     (S),
        .busy  (busy),
        .done  (done)
    );

    // Free-running clock, 10 time units per cycle
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference RV64 right shift built from the language shift operators
    function automatic logic [63:0] ref_shift(input logic [63:0] a, input logic [63:0] b,
                                              input logic ar, input logic wd);
        logic [63:0] x;
        logic [63:0] r;
        if (wd) begin
            if (ar) begin
                x = {{32{a[31]}}, a[31:0]};
                r = 64'($signed(x) >>> b[4:0]);
            end else begin
                x = {32'b0, a[31:0]};
                r = x >> b[4:0];
            end
            r = {{32{r[31]}}, r[31:0]};
        end else begin
            if (ar) begin
                r = 64'($signed(a) >>> b[5:0]);
            end else begin
                r = a >> b[5:0];
            end
        end
        return r;
    endfunction

    // Drive one request on the next falling edge, push its expectations,
    // scramble the inputs after acceptance, and compare when done arrives.
    task automatic applyStimulus(input logic [63:0] a, input logic [63:0] b,
                                 input logic ar, input logic wd,
                                 input logic [63:0] exp_s, input string name);
        logic [63:0] prev_s;
        logic [63:0] want_s;
        int          want_lat;
        int          cycles;
        bit          stable;
        @(negedge clk);
        A     = a;
        B     = b;
        arith = ar;
        word  = wd;
        start = 1'b1;
        exp_q.push_back(exp_s);
        lat_q.push_back(int'(wd ? {1'b0, b[4:0]} : b[5:0]) + 1);
        prev_s = S;
        stable = 1'b1;
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
            start = 1'b0;
            A     = ~a;
            B     = ~b;
            arith = ~ar;
            word  = ~wd;
            if (done !== 1'b1 && S !== prev_s) stable = 1'b0;
        end while (done !== 1'b1 && cycles < 80);
        want_s   = exp_q.pop_front();
        want_lat = lat_q.pop_front();
        total++;
        if (done !== 1'b1 || cycles != want_lat)
            $display("[TB] FAIL %s latency: got %0d cycles (done=%b), expected %0d", name, cycles, done, want_lat);
        else passed++;
        total++;
        if (S !== want_s)
            $display("[TB] FAIL %s result: got %h, expected %h", name, S, want_s);
        else passed++;
        total++;
        if (busy !== 1'b1)
            $display("[TB] FAIL %s busy in DONE: got %b, expected 1", name, busy);
        else passed++;
        total++;
        if (!stable)
            $display("[TB] FAIL %s S changed during SHIFT: got changed, expected held %h", name, prev_s);
        else passed++;
    endtask

    // Reset values, reset priority over start, and acceptance right after
    // reset is released.
    task automatic test_reset();
        reset = 1'b1;
        start = 1'b1;
        A     = 64'h1234_5678_9ABC_DEF0;
        B     = 64'd0;
        arith = 1'b0;
        word  = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (S !== 64'd0 || busy !== 1'b0 || done !== 1'b0)
            $display("[TB] FAIL reset_state: got S=%h busy=%b done=%b, expected 0/0/0", S, busy, done);
        else passed++;
        reset = 1'b0;
        @(negedge clk);
        start = 1'b0;
        total++;
        if (busy !== 1'b1 || done !== 1'b1 || S !== 64'h1234_5678_9ABC_DEF0)
            $display("[TB] FAIL first_after_reset: got S=%h busy=%b done=%b, expected 123456789abcdef0/1/1", S, busy, done);
        else passed++;
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || done !== 1'b0)
            $display("[TB] FAIL return_idle: got busy=%b done=%b, expected 0/0", busy, done);
        else passed++;
    endtask

    // Directed vectors from the reference cases
    task automatic test_directed();
        applyStimulus(64'h8000_0000_0000_0000, 64'd4,  1'b0, 1'b0, 64'h0800_0000_0000_0000, "srl4");
        applyStimulus(64'h8000_0000_0000_0000, 64'd4,  1'b1, 1'b0, 64'hF800_0000_0000_0000, "sra4");
        applyStimulus(64'h8000_0000_0000_0000, 64'd63, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, "sra63");
        applyStimulus(64'hDEAD_BEEF_8000_0000, 64'h24, 1'b0, 1'b1, 64'h0000_0000_0800_0000, "srlw4");
        applyStimulus(64'hDEAD_BEEF_8000_0000, 64'h24, 1'b1, 1'b1, 64'hFFFF_FFFF_F800_0000, "sraw4");
        applyStimulus(64'h0000_0000_8000_0001, 64'd0,  1'b0, 1'b1, 64'hFFFF_FFFF_8000_0001, "srlw0");
        applyStimulus(64'h0123_4567_89AB_CDEF, 64'hFFFF_FFC0, 1'b1, 1'b0, 64'h0123_4567_89AB_CDEF, "upper_b_ignored");
    endtask

    // Every shift amount in both shift types against the reference model
    task automatic test_sweep();
        logic [63:0] b;
        for (int ar = 0; ar < 2; ar++) begin
            for (int sh = 0; sh < 64; sh++) begin
                b = 64'(sh);
                applyStimulus(64'h8000_0000_0000_0001, b, ar[0], 1'b0,
                              ref_shift(64'h8000_0000_0000_0001, b, ar[0], 1'b0), "sweep");
            end
        end
        for (int i = 0; i < 8; i++) begin
            logic [63:0] a;
            logic [63:0] rb;
            logic        ra;
            logic        rw;
            a  = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            ra = 1'($urandom_range(1));
            rw = 1'($urandom_range(1));
            applyStimulus(a, rb, ra, rw, ref_shift(a, rb, ra, rw), "random");
        end
    endtask

    // New starts during SHIFT and during DONE must be dropped
    task automatic test_ignore_busy();
        int          pulses;
        logic [63:0] want;
        want = ref_shift(64'hF0F0_0000_0000_00FF, 64'd8, 1'b0, 1'b0);
        @(negedge clk);
        A     = 64'hF0F0_0000_0000_00FF;
        B     = 64'd8;
        arith = 1'b0;
        word  = 1'b0;
        start = 1'b1;
        exp_q.push_back(want);
        pulses = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (c == 3 || c == 5) begin
                start = 1'b1;
                A     = 64'hFFFF_FFFF_FFFF_FFFF;
                B     = 64'd1;
            end
            if (done === 1'b1) begin
                pulses++;
                start = 1'b1;
                A     = 64'h5555_5555_5555_5555;
                B     = 64'd0;
            end
        end
        start = 1'b0;
        want  = exp_q.pop_front();
        total++;
        if (pulses != 1)
            $display("[TB] FAIL ignore_busy pulses: got %0d, expected 1", pulses);
        else passed++;
        total++;
        if (S !== want)
            $display("[TB] FAIL ignore_busy result: got %h, expected %h", S, want);
        else passed++;
        total++;
        if (busy !== 1'b0)
            $display("[TB] FAIL ignore_busy idle: got busy=%b, expected 0", busy);
        else passed++;
    endtask

    // Requests issued in the first idle cycle after each done
    task automatic test_back_to_back();
        applyStimulus(64'h0000_0000_0000_00F0, 64'd2, 1'b0, 1'b0, 64'h0000_0000_0000_003C, "b2b_a");
        applyStimulus(64'hFFFF_0000_0000_0000, 64'd0, 1'b1, 1'b0, 64'hFFFF_0000_0000_0000, "b2b_b");
        applyStimulus(64'h0000_0000_0000_0001, 64'd1, 1'b0, 1'b1, 64'h0000_0000_0000_0000, "b2b_c");
    endtask

    // Reset in the middle of a shift aborts it without a done pulse
    task automatic test_reset_abort();
        int pulses;
        @(negedge clk);
        A     = 64'hAAAA_AAAA_AAAA_AAAA;
        B     = 64'd10;
        arith = 1'b1;
        word  = 1'b0;
        start = 1'b1;
        pulses = 0;
        repeat (3) begin
            @(negedge clk);
            start = 1'b0;
            if (done === 1'b1) pulses++;
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        total++;
        if (S !== 64'd0 || busy !== 1'b0 || done !== 1'b0)
            $display("[TB] FAIL abort_state: got S=%h busy=%b done=%b, expected 0/0/0", S, busy, done);
        else passed++;
        repeat (15) begin
            @(negedge clk);
            if (done === 1'b1) pulses++;
        end
        total++;
        if (pulses != 0)
            $display("[TB] FAIL abort_no_done: got %0d pulses, expected 0", pulses);
        else passed++;
        applyStimulus(64'h0000_0000_0000_0100, 64'd4, 1'b0, 1'b0, 64'h0000_0000_0000_0010, "after_abort");
    endtask

    // Run every scenario in order, then report
    initial begin
        total  = 0;
        passed = 0;
        test_reset();
        test_directed();
        test_sweep();
        test_ignore_busy();
        test_back_to_back();
        test_reset_abort();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
